// File: rtl/booth_multiplier.sv
// booth_multiplier: sequential radix-2 Booth 32x32->64 signed multiplier, one step per clock.
// Optional BOOTH_EARLY_EXIT_EN skips the iterations when either operand is zero.
module booth_multiplier (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] opera1,
  input  logic [31:0] opera2,
  output logic [63:0] result,
  output logic        valid,
  output logic        busy
);
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  state_t      state_q, state_d;
  logic [32:0] m_q, m_d, hi_q, hi_d, sum;
  logic [31:0] lo_q, lo_d;
  logic        qm1_q, qm1_d, valid_q, valid_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [63:0] result_q, result_d;
  always_comb begin
    sum = (lo_q[0] && !qm1_q) ? hi_q - m_q : (!lo_q[0] && qm1_q) ? hi_q + m_q : hi_q;
    state_d  = state_q;
    m_d      = m_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    qm1_d    = qm1_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    valid_d  = 1'b0;
    if (state_q == CALC) begin
      {hi_d, lo_d, qm1_d} = {sum[32], sum, lo_q};
      cnt_d = cnt_q + 5'd1;
      if (cnt_q == 5'd31) begin
        result_d = {hi_d[31:0], lo_d};
        valid_d  = 1'b1;
        state_d  = DONE;
      end
    end else if (start) begin
      m_d     = {opera1[31], opera1};
      hi_d    = '0;
      lo_d    = opera2;
      qm1_d   = 1'b0;
      cnt_d   = '0;
      state_d = CALC;
`ifdef BOOTH_EARLY_EXIT_EN
      if (opera1 == '0 || opera2 == '0) begin
        state_d  = DONE;
        result_d = '0;
        valid_d  = 1'b1;
      end
`endif
    end else if (state_q == DONE) begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      m_q      <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      qm1_q    <= 1'b0;
      cnt_q    <= '0;
      result_q <= '0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      m_q      <= m_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      qm1_q    <= qm1_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      valid_q  <= valid_d;
    end
  end
  assign result = result_q;
  assign valid  = valid_q;
  assign busy   = (state_q == CALC);
endmodule
